// File: rtl/apb_txn_monitor_if.sv
// ----------------------------------------------------------------------------
// apb_txn_monitor_if
//   APB bus bundle between a master and the RTC slave, with a third,
//   input-only view for passive observers such as apb_txn_monitor.
//
//   sel     : APB select
//   enable  : APB enable (ACCESS phase)
//   write   : direction, 1 = write
//   addr    : 8-bit address
//   wdata   : 32-bit write data
//   ready   : slave ready
//   rdata   : 32-bit read data
//
//   Modports: master (drives request), slave (drives response),
//             mon (observes everything).
// ----------------------------------------------------------------------------
interface apb_txn_monitor_if;
   logic        sel;
   logic        enable;
   logic        write;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;

   modport master (output sel, enable, write, addr, wdata,
                   input  ready, rdata);
   modport slave  (input  sel, enable, write, addr, wdata,
                   output ready, rdata);
   modport mon    (input  sel, enable, write, addr, wdata, ready, rdata);
endinterface

// File: rtl/apb_txn_monitor.sv
// ----------------------------------------------------------------------------
// apb_txn_monitor
//   Passive APB transaction monitor for the RTC register port. Tracks each
//   transfer through IDLE/SETUP/ACCESS, reports completed transfers with
//   their captured fields and decoded operation, counts completions, and
//   flags protocol violations and wait-state timeouts.
//
//   Parameters:
//     TIMEOUT : ready-low ACCESS cycles at which a transfer is aborted
//     CNT_W   : width of the saturating completed-transfer counter
//
//   Ports:
//     clk          : clock, all state on rising edge
//     reset        : asynchronous active-low reset
//     bus          : APB signals (mon modport, inputs only)
//     current_mode : decoded operation of the last completion, 000 otherwise
//     txn_valid    : one-cycle pulse after a completion
//     txn_addr/txn_write/txn_wdata/txn_rdata : fields of last completion
//     wait_cycles  : ready-low ACCESS cycles of last completion
//     txn_count    : completions since reset, saturating
//     prot_err     : one-cycle pulse on violation or timeout
//     err_code     : cause of last prot_err (01 enable w/o setup,
//                    10 sequence broken, 11 unstable in ACCESS, 00 timeout)
// ----------------------------------------------------------------------------
module apb_txn_monitor #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   apb_txn_monitor_if.mon   bus,
   output logic [2:0]       current_mode,
   output logic             txn_valid,
   output logic [7:0]       txn_addr,
   output logic             txn_write,
   output logic [31:0]      txn_wdata,
   output logic [31:0]      txn_rdata,
   output logic [7:0]       wait_cycles,
   output logic [CNT_W-1:0] txn_count,
   output logic             prot_err,
   output logic [1:0]       err_code
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   localparam logic [8:0]       TO_LIM  = 9'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   localparam logic [1:0] EC_TIMEOUT  = 2'b00;
   localparam logic [1:0] EC_NO_SETUP = 2'b01;
   localparam logic [1:0] EC_SEQUENCE = 2'b10;
   localparam logic [1:0] EC_UNSTABLE = 2'b11;

   state_t             state_q, state_d;
   logic [7:0]         lat_addr_q, lat_addr_d;
   logic               lat_write_q, lat_write_d;
   logic [31:0]        lat_wdata_q, lat_wdata_d;
   logic [7:0]         wait_q, wait_d;

   logic [2:0]         mode_d;
   logic               valid_d;
   logic [7:0]         taddr_d;
   logic               twrite_d;
   logic [31:0]        twdata_d;
   logic [31:0]        trdata_d;
   logic [7:0]         wcyc_d;
   logic [CNT_W-1:0]   cnt_d;
   logic               perr_d;
   logic [1:0]         ecode_d;

   // ACCESS-phase evaluation shared by SETUP and ACCESS states
   logic               in_access;
   logic [7:0]         eff_cnt;
   logic [8:0]         cnt_inc;
   logic               fields_moved;

   function automatic logic [2:0] decode_mode(input logic wr, input logic [7:0] a);
      logic [2:0] m;
      m = 3'b101;
      if (!wr && a == 8'h00)      m = 3'b001;
      else if (wr && a == 8'h00)  m = 3'b010;
      else if (wr && a == 8'h04)  m = 3'b011;
      else if (wr && a == 8'h08)  m = 3'b100;
      return m;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         lat_addr_q   <= '0;
         lat_write_q  <= 1'b0;
         lat_wdata_q  <= '0;
         wait_q       <= '0;
         current_mode <= '0;
         txn_valid    <= 1'b0;
         txn_addr     <= '0;
         txn_write    <= 1'b0;
         txn_wdata    <= '0;
         txn_rdata    <= '0;
         wait_cycles  <= '0;
         txn_count    <= '0;
         prot_err     <= 1'b0;
         err_code     <= '0;
      end else begin
         state_q      <= state_d;
         lat_addr_q   <= lat_addr_d;
         lat_write_q  <= lat_write_d;
         lat_wdata_q  <= lat_wdata_d;
         wait_q       <= wait_d;
         current_mode <= mode_d;
         txn_valid    <= valid_d;
         txn_addr     <= taddr_d;
         txn_write    <= twrite_d;
         txn_wdata    <= twdata_d;
         txn_rdata    <= trdata_d;
         wait_cycles  <= wcyc_d;
         txn_count    <= cnt_d;
         prot_err     <= perr_d;
         err_code     <= ecode_d;
      end
   end

   // The FSM state names the phase of the previous bus cycle, so the cycle
   // observed while in SETUP is the first ACCESS cycle. It is evaluated with
   // the ACCESS rules and a zero wait count, which lets a zero-wait transfer
   // complete there; SETUP->ACCESS is taken only when that cycle is a wait.
   always_comb begin
      in_access    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
      eff_cnt      = (state_q == ST_SETUP) ? 8'd0 : wait_q;
      cnt_inc      = {1'b0, eff_cnt} + 9'd1;
      fields_moved = (bus.addr  != lat_addr_q)  ||
                     (bus.write != lat_write_q) ||
                     (bus.wdata != lat_wdata_q);
   end

   always_comb begin
      state_d     = state_q;
      lat_addr_d  = lat_addr_q;
      lat_write_d = lat_write_q;
      lat_wdata_d = lat_wdata_q;
      wait_d      = wait_q;
      mode_d      = 3'b000;
      valid_d     = 1'b0;
      taddr_d     = txn_addr;
      twrite_d    = txn_write;
      twdata_d    = txn_wdata;
      trdata_d    = txn_rdata;
      wcyc_d      = wait_cycles;
      cnt_d       = txn_count;
      perr_d      = 1'b0;
      ecode_d     = err_code;

      if (state_q == ST_IDLE) begin
         if (bus.sel && !bus.enable) begin
            state_d     = ST_SETUP;
            lat_addr_d  = bus.addr;
            lat_write_d = bus.write;
            lat_wdata_d = bus.wdata;
         end else if (bus.sel && bus.enable) begin
            perr_d  = 1'b1;
            ecode_d = EC_NO_SETUP;
         end
      end else if (in_access) begin
         state_d = ST_IDLE;
         if (!bus.sel || !bus.enable) begin
            perr_d  = 1'b1;
            ecode_d = EC_SEQUENCE;
         end else if (bus.ready) begin
            valid_d  = 1'b1;
            mode_d   = decode_mode(lat_write_q, lat_addr_q);
            taddr_d  = lat_addr_q;
            twrite_d = lat_write_q;
            twdata_d = lat_wdata_q;
            trdata_d = bus.rdata;
            wcyc_d   = eff_cnt;
            if (txn_count != '1)
               cnt_d = txn_count + CNT_ONE;
         end else if (fields_moved) begin
            perr_d  = 1'b1;
            ecode_d = EC_UNSTABLE;
         end else if (cnt_inc >= TO_LIM) begin
            perr_d  = 1'b1;
            ecode_d = EC_TIMEOUT;
         end else begin
            state_d = ST_ACCESS;
            wait_d  = cnt_inc[7:0];
         end
      end else begin
         state_d = ST_IDLE;
      end
   end

endmodule
